iter_mag_cmp: RTL and testbench
===============================

// Module: iter_mag_cmp
// PURPOSE
//   Parametrised multi-cycle magnitude comparator; successor to the 4-bit equality comparator.
//   Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, and stops early on the first differing chunk.
//   Reports eq/lt/gt in unsigned or two's-complement mode.
//   A start/busy/done handshake lets a controller or datapath FSM issue one compare at a time.
// PARAMETERS
//   WIDTH  16  operand width in bits; must be a multiple of CHUNK.
//   CHUNK  4   bits compared per cycle; NCH = WIDTH/CHUNK chunks.
// PORTS
//   clk          in   1      single clock; all state updates on the rising edge.
//   rst          in   1      synchronous, active-high reset.
//   start        in   1      request a compare; sampled only while busy=0.
//   signed_mode  in   1      1 = two's-complement compare, 0 = unsigned; captured with start.
//   n1           in   WIDTH  operand A; captured with start.
//   n2           in   WIDTH  operand B; captured with start.
//   busy         out  1      compare in progress.
//   done         out  1      one-cycle pulse: eq/lt/gt are valid from this cycle.
//   eq           out  1      A == B (held until the next accepted start).
//   lt           out  1      A < B (held).
//   gt           out  1      A > B (held).
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, eq, lt, gt all 0; chunk index = 0.
//   FSM states: IDLE, RUN.
//   IDLE
//     - start=1 at edge t0: capture n1/n2 into shift registers.
//     - If signed_mode=1, invert bit WIDTH-1 of both copies (offset binary), so the unsigned compare is correct.
//     - Clear eq/lt/gt. Set idx=0. Go to RUN; busy=1 from t0.
//   RUN, at each edge
//     - Compare chunk idx (bits WIDTH-1-idx*CHUNK down to WIDTH-(idx+1)*CHUNK).
//     - Chunks differ: gt=1 if A chunk > B chunk, otherwise lt=1. Set done=1, busy=0, go to IDLE.
//     - Chunks equal and idx=NCH-1: set eq=1, done=1, busy=0, go to IDLE.
//     - Otherwise: idx += 1 and stay in RUN.
//   Latency: done is high in the cycle after edge t0+1+j, where j is the deciding chunk index.
//     - Best case: 1 edge after t0 (MSB chunk differs).
//     - Worst case: NCH edges after t0 (operands equal, or LSB chunk differs).
//   done: high for exactly one cycle per accepted start; never high while busy=1.
//   Result flags: exactly one of eq/lt/gt is 1 after any done. All three are 0 from an accepted start until its done, and after reset.
//   start while busy=1: ignored; the captured operands and signed_mode must not change.
//   start in the done cycle: accepted, because the FSM is already in IDLE. This gives back-to-back compares with no bubble.
//   Input changes after capture: n1/n2/signed_mode changes have no effect on the compare in progress.
//   rst mid-RUN: abort immediately to the reset state. No done pulse for the aborted compare.
//   rst has priority over start in the same cycle.
//   Index counter: width clog2(NCH), minimum 1 bit. It must not wrap past NCH-1.
// TESTING (WIDTH=16, CHUNK=4)
//   1. Hold rst=1 for 2 cycles -> busy=done=eq=lt=gt=0. Release, no start -> outputs stay 0.
//   2. start with n1=n2=0x1234, unsigned -> busy for 4 cycles. done with eq=1, lt=gt=0 on the 4th edge after start.
//   3. start with n1=0xF000, n2=0x8000, unsigned -> gt=1, done after 1 edge (early exit).
//      Also: n1=0x000C, n2=0x0008 -> gt=1 after 4 edges.
//   4. n1=0xFFFF, n2=0x0001: signed_mode=1 -> lt=1; signed_mode=0 -> gt=1.
//      Also: signed 0x8000 vs 0x7FFF -> lt=1.
//   5. start with 0x0000 vs 0x0001, then change n2 and pulse start during busy -> both ignored; lt=1 after 4 edges.
//      Also: assert rst at edge 2 -> no done, all outputs 0.
//   6. Hold start=1 continuously with new operands each done cycle -> one done per compare, no idle cycle between compares.
//      Also: random self-check of 1000 pairs against n1<n2 / == / > in both modes.

Source files
------------

// File: rtl/iter_mag_cmp_if.sv
// Purpose: start/result bundle between a compare requester and iter_mag_cmp.
// Latency: none, wires only.
// Backpressure: requester must watch busy; start is ignored while busy=1.
interface iter_mag_cmp_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] n1;
    logic [WIDTH-1:0] n2;
    logic             busy;
    logic             done;
    logic             eq;
    logic             lt;
    logic             gt;

    modport master (
        output start, signed_mode, n1, n2,
        input  busy, done, eq, lt, gt
    );

    modport slave (
        input  start, signed_mode, n1, n2,
        output busy, done, eq, lt, gt
    );
endinterface

// File: rtl/iter_mag_cmp.sv
// Purpose: multi-cycle eq/lt/gt magnitude compare, CHUNK bits per cycle MSB first, early exit on first difference.
// Latency: done 1..NCH edges after the accepting edge (deciding chunk index + 1).
// Backpressure: start ignored while busy; result flags held until the next accepted start.
module iter_mag_cmp #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst,
    iter_mag_cmp_if.slave  bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [IW-1:0]    idx;
    logic             done_q;
    logic             eq_q;
    logic             lt_q;
    logic             gt_q;
    logic [CHUNK-1:0] a_chk;
    logic [CHUNK-1:0] b_chk;
    logic             chunk_ne;
    logic             load;
    logic             decide;

    // Operands shift left once per cycle, so the chunk under test is always the top one.
    assign a_chk    = a_sr[WIDTH-1 -: CHUNK];
    assign b_chk    = b_sr[WIDTH-1 -: CHUNK];
    assign chunk_ne = (a_chk != b_chk);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept start only in IDLE; leave RUN on the first differing chunk or the last chunk.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        decide    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (chunk_ne || (idx == LAST_IDX)) begin
                    decide    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture (with sign-bit flip to offset binary for signed mode), shift, and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            idx    <= '0;
            done_q <= 1'b0;
            eq_q   <= 1'b0;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
        end else begin
            done_q <= decide;
            if (load) begin
                a_sr <= bus.n1 ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
                b_sr <= bus.n2 ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
                idx  <= '0;
                eq_q <= 1'b0;
                lt_q <= 1'b0;
                gt_q <= 1'b0;
            end else if (decide) begin
                eq_q <= !chunk_ne;
                gt_q <= chunk_ne && (a_chk > b_chk);
                lt_q <= chunk_ne && (a_chk < b_chk);
            end else if (state == RUN) begin
                a_sr <= a_sr << CHUNK;
                b_sr <= b_sr << CHUNK;
                idx  <= idx + 1'b1;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_q;
    assign bus.eq   = eq_q;
    assign bus.lt   = lt_q;
    assign bus.gt   = gt_q;
endmodule

// File: tb/tb_iter_mag_cmp.sv
// Purpose: directed and random self-check of iter_mag_cmp at WIDTH=16, CHUNK=4.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: bench waits on done with a bounded cycle budget per compare.
module tb_iter_mag_cmp;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;
    localparam logic [2:0] F_LT = 3'b100;
    localparam logic [2:0] F_EQ = 3'b010;
    localparam logic [2:0] F_GT = 3'b001;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [2:0]  f;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    iter_mag_cmp_if #(.WIDTH(WIDTH)) bus();

    iter_mag_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [2:0] fl;
    logic [4:0] outs;
    assign fl   = {bus.lt, bus.eq, bus.gt};
    assign outs = {bus.busy, bus.done, bus.eq, bus.lt, bus.gt};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        x = a ^ b;
        for (int j = 0; j < NCH; j++) begin
            if (x[15-4*j -: 4] != 4'h0) return j + 1;
        end
        return NCH;
    endfunction

    function automatic logic [2:0] exp_flags(input logic [15:0] a, input logic [15:0] b, input logic sm);
        if (a == b) return F_EQ;
        if (sm) return ($signed(a) < $signed(b)) ? F_LT : F_GT;
        return (a < b) ? F_LT : F_GT;
    endfunction

    // One isolated compare: start for a single cycle, wait for done, check latency, flags and pulse width.
    task automatic run_cmp(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic sm, input logic [2:0] ef, input int elat);
        int e;
        bus.n1 = a;
        bus.n2 = b;
        bus.signed_mode = sm;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, ".busy"}, bus.busy, 1);
        check({tag, ".clr"}, fl, 0);
        e = 0;
        while (!bus.done && e < 3*NCH) begin
            tick();
            e++;
        end
        check({tag, ".lat"}, e, elat);
        check({tag, ".flags"}, fl, ef);
        check({tag, ".busy_at_done"}, bus.busy, 0);
        tick();
        check({tag, ".pulse"}, bus.done, 0);
        check({tag, ".hold"}, fl, ef);
    endtask

    initial begin
        int   e;
        int   dn;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        vec_t v[4];

        rst = 1'b1;
        bus.start = 1'b0;
        bus.signed_mode = 1'b0;
        bus.n1 = '0;
        bus.n2 = '0;
        tick();
        tick();
        check("reset.outs", outs, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle.outs", outs, 0);

        run_cmp("eq1234", 16'h1234, 16'h1234, 1'b0, F_EQ, 4);
        run_cmp("gt_msb", 16'hF000, 16'h8000, 1'b0, F_GT, 1);
        run_cmp("gt_lsb", 16'h000C, 16'h0008, 1'b0, F_GT, 4);
        run_cmp("s_m1_1", 16'hFFFF, 16'h0001, 1'b1, F_LT, 1);
        run_cmp("u_ff_1", 16'hFFFF, 16'h0001, 1'b0, F_GT, 1);
        run_cmp("s_min_max", 16'h8000, 16'h7FFF, 1'b1, F_LT, 1);

        // Operand change and a second start while busy must not disturb the compare.
        bus.n1 = 16'h0000;
        bus.n2 = 16'h0001;
        bus.signed_mode = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.n2 = 16'h0000;
        bus.signed_mode = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ign.busy", bus.busy, 1);
        e = 1;
        while (!bus.done && e < 3*NCH) begin
            tick();
            e++;
        end
        check("ign.lat", e, 4);
        check("ign.flags", fl, F_LT);
        tick();

        // Reset two edges into a compare aborts it with no done pulse.
        bus.n1 = 16'h0000;
        bus.n2 = 16'h0000;
        bus.signed_mode = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.outs", outs, 0);
        dn = 0;
        repeat (6) begin
            tick();
            dn += int'(bus.done);
        end
        check("abort.nodone", dn, 0);
        check("abort.idle", outs, 0);
        run_cmp("post_abort", 16'h0010, 16'h0020, 1'b0, F_LT, 3);

        // Back-to-back compares with start held high: new operands presented in each done cycle.
        v[0] = '{16'h1234, 16'h1234, 1'b0, F_EQ, 4};
        v[1] = '{16'hF000, 16'h8000, 1'b0, F_GT, 1};
        v[2] = '{16'h0001, 16'h0002, 1'b0, F_LT, 4};
        v[3] = '{16'h8000, 16'h0001, 1'b1, F_LT, 1};
        bus.n1 = v[0].a;
        bus.n2 = v[0].b;
        bus.signed_mode = v[0].sm;
        bus.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = 0;
            do begin
                tick();
                e++;
            end while (!bus.done && e < 3*NCH);
            check("b2b.lat", e, v[k].lat + 1);
            check("b2b.flags", fl, v[k].f);
            check("b2b.busy_at_done", bus.busy, 0);
            if (k < 3) begin
                bus.n1 = v[k+1].a;
                bus.n2 = v[k+1].b;
                bus.signed_mode = v[k+1].sm;
            end else begin
                bus.start = 1'b0;
            end
        end
        tick();
        check("b2b.end_done", bus.done, 0);
        check("b2b.end_busy", bus.busy, 0);

        // Random pairs, biased toward equal and near-equal operands to exercise late chunks.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            rs = 1'($urandom_range(0, 1));
            run_cmp("rnd", ra, rb, rs, exp_flags(ra, rb, rs), exp_lat(ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
